// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Screen/sprite constants, motion FSM states and the axis-step rule.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int unsigned c_SCREEN_W = 640;
  localparam int unsigned c_SCREEN_H = 480;
  localparam int unsigned c_SPRITE_W = 64;
  localparam int unsigned c_SPRITE_H = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_COMMIT = 2'd3
  } motion_state_t;

  typedef logic [1:0] scene_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One axis of motion: advance by spd, clamp to [0, max] and reflect on contact.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [2:0] spd, input logic [9:0] max);
    logic [10:0] nx;
    axis_t       r;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    nx    = {1'b0, pos} + {8'd0, spd};
    if (dir) begin
      if (nx >= {1'b0, max}) begin
        r.pos = max;
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = nx[9:0];
      end
    end else begin
      if (pos < {7'd0, spd}) begin
        r.pos = '0;
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - {7'd0, spd};
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// ============================================================================
// Module  : sprite_motion_ctrl
// Brief   : Per-frame sprite motion sequencer with wall bounce and scene count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SCREEN_W = c_SCREEN_W,
  parameter int unsigned SCREEN_H = c_SCREEN_H,
  parameter int unsigned SPRITE_W = c_SPRITE_W,
  parameter int unsigned SPRITE_H = c_SPRITE_H,
  parameter int unsigned START_X  = 50,
  parameter int unsigned START_Y  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       corner,
  output logic [1:0] scene,
  output logic       busy
);

  localparam logic [9:0] c_max_x   = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] c_max_y   = 10'(SCREEN_H - SPRITE_H);
  localparam logic [9:0] c_start_x = 10'(START_X);
  localparam logic [9:0] c_start_y = 10'(START_Y);

  motion_state_t state_q, state_d;

  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic       sdir_x_q, sdir_x_d, sdir_y_q, sdir_y_d;
  logic       hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [2:0] spd_q, spd_d;
  logic       step_pend_q, step_pend_d;

  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       bounce_q, bounce_d, corner_q, corner_d;
  scene_t     scene_q, scene_d;
  logic       busy_q, busy_d;

  logic  w_accept;
  axis_t w_ax, w_ay;

  assign w_accept = (state_q == ST_IDLE) && frame_tick && (!pause || step_pend_q);
  assign w_ax     = axis_step(sx_q, sdir_x_q, spd_q, c_max_x);
  assign w_ay     = axis_step(sy_q, sdir_y_q, spd_q, c_max_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_accept) state_d = ST_MOVE_X;
      ST_MOVE_X: state_d = ST_MOVE_Y;
      ST_MOVE_Y: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sx_d      = sx_q;
    sy_d      = sy_q;
    sdir_x_d  = sdir_x_q;
    sdir_y_d  = sdir_y_q;
    hit_x_d   = hit_x_q;
    hit_y_d   = hit_y_q;
    spd_d     = spd_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    bounce_d  = 1'b0;
    corner_d  = 1'b0;
    scene_d   = scene_q;
    busy_d    = (state_d != ST_IDLE);

    // A step arriving alongside an accepted tick stays armed for the next one.
    step_pend_d = step_pend_q;
    if (w_accept) step_pend_d = 1'b0;
    if (step)     step_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) spd_d = {1'b0, speed} + 3'd1;
      end
      ST_MOVE_X: begin
        sx_d     = w_ax.pos;
        sdir_x_d = w_ax.dir;
        hit_x_d  = w_ax.hit;
      end
      ST_MOVE_Y: begin
        sy_d     = w_ay.pos;
        sdir_y_d = w_ay.dir;
        hit_y_d  = w_ay.hit;
      end
      ST_COMMIT: begin
        pos_x_d  = sx_q;
        pos_y_d  = sy_q;
        dir_x_d  = sdir_x_q;
        dir_y_d  = sdir_y_q;
        bounce_d = hit_x_q | hit_y_q;
        corner_d = hit_x_q & hit_y_q;
        if (hit_x_q | hit_y_q) scene_d = scene_q + 2'd1;
        hit_x_d  = 1'b0;
        hit_y_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q        <= c_start_x;
      sy_q        <= c_start_y;
      sdir_x_q    <= 1'b1;
      sdir_y_q    <= 1'b1;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      spd_q       <= 3'd1;
      step_pend_q <= 1'b0;
      pos_x_q     <= c_start_x;
      pos_y_q     <= c_start_y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      bounce_q    <= 1'b0;
      corner_q    <= 1'b0;
      scene_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sdir_x_q    <= sdir_x_d;
      sdir_y_q    <= sdir_y_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      spd_q       <= spd_d;
      step_pend_q <= step_pend_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      bounce_q    <= bounce_d;
      corner_q    <= corner_d;
      scene_q     <= scene_d;
      busy_q      <= busy_d;
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign dir_x  = dir_x_q;
  assign dir_y  = dir_y_q;
  assign bounce = bounce_q;
  assign corner = corner_q;
  assign scene  = scene_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
// ============================================================================
// Module  : tb_sprite_motion_ctrl
// Brief   : Self-checking bench for sprite_motion_ctrl against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic       dir_x, dir_y, bounce, corner, busy;
  logic [1:0] scene;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  sprite_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .speed(speed),
    .pause(pause), .step(step), .pos_x(pos_x), .pos_y(pos_y),
    .dir_x(dir_x), .dir_y(dir_y), .bounce(bounce), .corner(corner),
    .scene(scene), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: on acceptance the whole frame result is computed at once
  // and published after a fixed three-cycle latency.
  int m_x = 50, m_y = 50, m_scene = 0, left = 0, s = 1;
  bit m_dx = 1'b1, m_dy = 1'b1, m_bounce = 1'b0, m_corner = 1'b0, pend = 1'b0;
  int f_x, f_y;
  bit f_dx, f_dy, f_hx, f_hy;

  task automatic move(input int p, input bit d, input int sp, input int lim,
                      output int np, output bit nd, output bit hit);
    hit = 1'b0;
    nd  = d;
    if (d) begin
      np = p + sp;
      if (np >= lim) begin np = lim; nd = 1'b0; hit = 1'b1; end
    end else begin
      np = p - sp;
      if (np < 0) begin np = 0; nd = 1'b1; hit = 1'b1; end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x = 50; m_y = 50; m_dx = 1'b1; m_dy = 1'b1; m_scene = 0;
      m_bounce = 1'b0; m_corner = 1'b0; left = 0; pend = 1'b0;
    end else begin
      m_bounce = 1'b0;
      m_corner = 1'b0;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          m_x = f_x; m_y = f_y; m_dx = f_dx; m_dy = f_dy;
          m_bounce = f_hx | f_hy;
          m_corner = f_hx & f_hy;
          if (m_bounce) m_scene = (m_scene + 1) % 4;
        end
      end else if (frame_tick && (!pause || pend)) begin
        s = int'(speed) + 1;
        move(m_x, m_dx, s, 576, f_x, f_dx, f_hx);
        move(m_y, m_dy, s, 448, f_y, f_dy, f_hy);
        left = 3;
        pend = 1'b0;
      end
      if (step) pend = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("pos_x",  int'(pos_x),  m_x);
      check("pos_y",  int'(pos_y),  m_y);
      check("dir_x",  int'(dir_x),  int'(m_dx));
      check("dir_y",  int'(dir_y),  int'(m_dy));
      check("bounce", int'(bounce), int'(m_bounce));
      check("corner", int'(corner), int'(m_corner));
      check("scene",  int'(scene),  m_scene);
      check("busy",   int'(busy),   int'(left > 0));
    end
  end

  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  int nbusy;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    check("rst_pos_x", int'(pos_x), 50);
    check("rst_pos_y", int'(pos_y), 50);
    check("rst_dir_x", int'(dir_x), 1);
    check("rst_dir_y", int'(dir_y), 1);
    check("rst_scene", int'(scene), 0);
    check("rst_busy",  int'(busy),  0);

    // Tick held for two edges: the second one lands while busy and is dropped.
    frame_tick = 1'b1;
    speed      = 2'd0;
    nbusy      = 0;
    @(negedge clk);
    nbusy = nbusy + int'(busy);
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nbusy = nbusy + int'(busy);
      @(negedge clk);
    end
    check("busy_cycles", nbusy, 3);
    check("first_pos_x", int'(pos_x), 51);
    check("first_pos_y", int'(pos_y), 51);

    pause = 1'b1;
    repeat (5) frame();
    check("pause_pos_x", int'(pos_x), 51);
    check("pause_pos_y", int'(pos_y), 51);

    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    frame();
    frame();
    check("step_pos_x", int'(pos_x), 52);
    check("step_pos_y", int'(pos_y), 52);
    pause = 1'b0;

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      frame_tick = ($urandom % 6) == 0;
      speed      = 2'($urandom);
      step       = ($urandom % 40) == 0;
      if (($urandom % 400) == 0) pause = ~pause;
    end
    frame_tick = 1'b0;
    step       = 1'b0;
    pause      = 1'b0;
    repeat (6) @(negedge clk);

    // Reset while the sequence is in its Y update.
    speed      = 2'd3;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pos_x", int'(pos_x), 50);
    check("midrst_pos_y", int'(pos_y), 50);
    check("midrst_busy",  int'(busy),  0);
    check("midrst_scene", int'(scene), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame();
    check("post_rst_pos_x", int'(pos_x), 54);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Per-frame motion controller for the bouncing SJSU sprite. It accepts a one-cycle frame tick from the sync-generator domain and sequences X then Y position updates with a selectable speed and wall bounces. It counts collisions into a scene index and publishes position only at commit, so the pixel renderer always sees one consistent coordinate pair per frame. It sits between `hvsync_generator` and the sprite/background renderer, and replaces the inline bounce logic in the top level.

## Interface
Parameters:
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `SPRITE_W`, 64, sprite width in pixels
- `SPRITE_H`, 32, sprite height in pixels
- `START_X`, 50, reset X position
- `START_Y`, 50, reset Y position

Ports:
- `clk` in 1: pixel clock; the only clock
- `rst_n` in 1: asynchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse at hpos==0 && vpos==0
- `speed` in 2: pixels per frame minus one (1..4 px); sampled when a tick is accepted
- `pause` in 1: level; while high, ticks are ignored unless a step is pending
- `step` in 1: one-cycle pulse; arms a single update while paused
- `pos_x` out 10: committed sprite left edge
- `pos_y` out 10: committed sprite top edge
- `dir_x` out 1: 1 = moving right
- `dir_y` out 1: 1 = moving down
- `bounce` out 1: one-cycle pulse at commit if any wall was hit
- `corner` out 1: one-cycle pulse at commit if both axes hit
- `scene` out 2: collision counter, wraps 3→0
- `busy` out 1: high in any state other than IDLE

## Operation
- Limits: MAX_X = SCREEN_W−SPRITE_W (576), MAX_Y = SCREEN_H−SPRITE_H (448).
- FSM states: IDLE → MOVE_X → MOVE_Y → COMMIT → IDLE.
- IDLE accepts `frame_tick` when `pause`=0, or when `pause`=1 and `step_pend`=1.
  - On accept: latch `spd` = `speed`+1, clear `step_pend`, go to MOVE_X.
- MOVE_X uses an 11-bit sum `nx` = `sx` ± `spd`.
  - Positive direction: if `nx` ≥ MAX_X, set `sx`=MAX_X, flip dir, set `hit_x`. Otherwise `sx`=`nx`.
  - Negative direction: if `sx` < `spd`, set `sx`=0, flip dir, set `hit_x`. Otherwise `sx`=`sx`−`spd`.
- MOVE_Y applies the same rule to `sy`, MAX_Y and `hit_y`.
- COMMIT:
  - Copy `sx`/`sy`/dirs to the outputs.
  - `bounce` = `hit_x`|`hit_y`; `corner` = `hit_x`&`hit_y`.
  - `scene` increments by exactly 1 if `bounce`, including on a corner hit.
  - Clear the hit flags.
- `step_pend` is set by `step` in any state and persists until consumed. Multiple steps collapse into one.
- A `frame_tick` arriving while `busy` is dropped; there is no queueing.
- `pause` toggling mid-sequence has no effect until the next IDLE.
- Reset values:
  - `pos_x`=START_X, `pos_y`=START_Y
  - `dir_x`=1, `dir_y`=1
  - `scene`=0, `bounce`=0, `corner`=0, `busy`=0
  - state IDLE, `step_pend`=0
- Reset mid-sequence aborts immediately to the reset values; partial shadow updates are discarded.

## Timing
- Tick accepted at edge t: MOVE_X at t+1, MOVE_Y at t+2, COMMIT at t+3. Outputs are valid after edge t+3, and `bounce`/`corner` are high for that single cycle.
- `busy` is high for cycles t+1..t+3.
- All outputs are registered; there are no combinational paths from input to output.
- A tick and a step in the same cycle while paused: the step sets `step_pend` at that edge, the tick is not accepted, and the step is used by the next tick.

## Structure
- Shared package `vga_pkg` holds:
  - screen constants (640/480)
  - sprite size constants (64/32)
  - the `motion_state_t` enum
  - the 2-bit `scene_t`
- Single module with no sub-module. The axis-update rule is a function in `vga_pkg`, `axis_step(pos, dir, spd, max) → {pos, dir, hit}`, used once for X and once for Y.

## Test plan
- Reset: release `rst_n` → `pos`=(50,50), dirs=1, `scene`=0, `busy`=0. Assert `rst_n` low in MOVE_Y → outputs return to the reset values.
- Normal move: `speed`=0, one tick → after 3 cycles `pos`=(51,51), `bounce`=0, `busy` high for exactly 3 cycles.
- Right-wall bounce: `sx`=574, `dir_x`=1, `speed`=3 → `pos_x`=576, `dir_x`=0, `bounce` pulse, `scene` 0→1.
- Corner: `sx`=2, `sy`=446, `dir_x`=0, `dir_y`=1, `speed`=3 → `pos`=(0,448), both dirs flip, `corner`=1, `scene` increments by 1 only. Four bounces → `scene` wraps to 0.
- Pause/step: `pause`=1, 5 ticks → `pos` unchanged. Two `step` pulses then 2 ticks → exactly one update.
- Tick while busy: tick again 1 cycle after an accepted tick → the second tick is dropped and `pos` advances once.
